// File: rtl/cdm_err_monitor_if.sv
// cdm_err_monitor_if: valid/ready channel carrying operand A, operand B and approximate product R
interface cdm_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] r;
  modport master (output in_valid, a, b, r, input in_ready);
  modport slave (input in_valid, a, b, r, output in_ready);
endinterface

// File: rtl/cdm_err_monitor.sv
// cdm_err_monitor: 3-stage error-statistics monitor for a 16x16 approximate multiplier (CDM_ERR_SQ_EN adds saturating ed_sq_sum)
module cdm_err_monitor #(
  parameter int unsigned N_SAMPLES = 1000000,
  parameter int unsigned SUM_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clr,
  cdm_err_monitor_if.slave   s,
  output logic               busy,
  output logic               done,
  output logic [31:0]        sample_cnt,
  output logic [31:0]        err_cnt,
  output logic [SUM_W-1:0]   ed_sum,
  output logic [31:0]        ed_max,
  output logic [15:0]        max_a,
  output logic [15:0]        max_b
`ifdef CDM_ERR_SQ_EN
  ,
  output logic [2*SUM_W-1:0] ed_sq_sum
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic dr_q, dr_d;
  logic go, wipe, accept;
  logic v1_q, v2_q;
  logic [15:0] a1_q, b1_q, a2_q, b2_q;
  logic [31:0] r1_q, ed1, ed2_q;
  logic [32:0] diff;
  logic [31:0] sample_cnt_q, err_cnt_q, ed_max_q;
  logic [SUM_W-1:0] ed_sum_q;
  logic [SUM_W:0] sum_ext;
  logic [15:0] max_a_q, max_b_q;
  assign s.in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign accept = s.in_valid && s.in_ready;
  assign go = start && !clr && (state_q == IDLE || state_q == DONE);
  assign wipe = clr || go;
  assign diff = {1'b0, 32'(a1_q) * 32'(b1_q)} - {1'b0, r1_q};
  assign ed1 = diff[32] ? 32'(-diff) : diff[31:0];
  assign sum_ext = {1'b0, ed_sum_q} + (SUM_W+1)'(ed2_q);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt = err_cnt_q;
  assign ed_sum = ed_sum_q;
  assign ed_max = ed_max_q;
  assign max_a = max_a_q;
  assign max_b = max_b_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    dr_d = dr_q;
    if (clr) begin
      state_d = IDLE;
    end else if (go) begin
      state_d = RUN;
      acc_d = '0;
    end else if (state_q == RUN && accept) begin
      acc_d = acc_q + 32'd1;
      if (N_SAMPLES != 0 && acc_d == 32'(N_SAMPLES)) begin
        state_d = DRAIN;
        dr_d = 1'b0;
      end
    end else if (state_q == DRAIN) begin
      dr_d = 1'b1;
      state_d = dr_q ? DONE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      dr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      dr_q <= dr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q <= '0;
      ed_sum_q <= '0;
      ed_max_q <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) begin
        a1_q <= s.a;
        b1_q <= s.b;
        r1_q <= s.r;
      end
      a2_q <= a1_q;
      b2_q <= b1_q;
      ed2_q <= ed1;
      if (v2_q) begin
        sample_cnt_q <= sample_cnt_q + 32'd1;
        err_cnt_q <= err_cnt_q + 32'(ed2_q != 32'd0);
        ed_sum_q <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (ed2_q > ed_max_q) begin
          ed_max_q <= ed2_q;
          max_a_q <= a2_q;
          max_b_q <= b2_q;
        end
      end
    end
  end
`ifdef CDM_ERR_SQ_EN
  logic [63:0] sq2_q;
  logic [2*SUM_W-1:0] sq_sum_q;
  logic [2*SUM_W:0] sq_ext;
  assign sq_ext = {1'b0, sq_sum_q} + (2*SUM_W+1)'(sq2_q);
  assign ed_sq_sum = sq_sum_q;
  always_ff @(posedge clk) begin
    sq2_q <= 64'(ed1) * 64'(ed1);
    if (rst || wipe) sq_sum_q <= '0;
    else if (v2_q) sq_sum_q <= sq_ext[2*SUM_W] ? '1 : sq_ext[2*SUM_W-1:0];
  end
`endif
endmodule

// File: tb/tb_cdm_err_monitor.sv
// tb_cdm_err_monitor: randomized self-checking bench against a sample-list error-statistics model
module tb_cdm_err_monitor;
  localparam int N = 4;
  localparam int SW = 33;
  localparam longint SAT = (64'd1 << SW) - 1;
  localparam logic [66:0] SQSAT = (67'd1 << (2*SW)) - 67'd1;
  logic clk = 1'b0;
  logic rst, start, clr;
  logic busy, done;
  logic [31:0] sample_cnt, err_cnt, ed_max;
  logic [SW-1:0] ed_sum;
  logic [15:0] max_a, max_b;
`ifdef CDM_ERR_SQ_EN
  logic [2*SW-1:0] ed_sq_sum;
`endif
  cdm_err_monitor_if bus();
  cdm_err_monitor #(.N_SAMPLES(N), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .s(bus),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .ed_sum(ed_sum), .ed_max(ed_max), .max_a(max_a), .max_b(max_b)
`ifdef CDM_ERR_SQ_EN
    , .ed_sq_sum(ed_sq_sum)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  longint m_cnt, m_err, m_sum, m_max;
  int unsigned m_a, m_b;
  logic [66:0] m_sq;
  int unsigned ta[4], tb_[4], tr[4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic longint edist(input longint a, input longint b, input longint r);
    longint d;
    d = a * b - r;
    return d < 0 ? -d : d;
  endfunction
  task automatic model_clear;
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_a = 0; m_b = 0; m_sq = '0;
  endtask
  task automatic model_add(input int unsigned a, input int unsigned b, input int unsigned r);
    longint e;
    logic [63:0] e64;
    e = edist(longint'(a), longint'(b), longint'(r));
    e64 = 64'(e);
    m_cnt++;
    if (e != 0) m_err++;
    m_sum = (m_sum + e > SAT) ? SAT : m_sum + e;
    m_sq = (m_sq + 67'(e64 * e64) > SQSAT) ? SQSAT : m_sq + 67'(e64 * e64);
    if (e > m_max) begin
      m_max = e; m_a = a; m_b = b;
    end
  endtask
  task automatic test_reset;
    rst = 1; start = 0; clr = 0;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.r = '0;
    tick; tick;
    checks++; if ({bus.in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL reset flags got %b exp 000", {bus.in_ready, busy, done}); end
    checks++; if (sample_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL reset counters got %0d/%0d exp 0/0", sample_cnt, err_cnt); end
    checks++; if (ed_sum !== 0 || ed_max !== 0 || max_a !== 0 || max_b !== 0) begin errors++; $display("FAIL reset stats got %0d %0d %0d %0d exp 0", ed_sum, ed_max, max_a, max_b); end
    rst = 0;
    tick;
  endtask
  task automatic test_batch(input string name);
    int n;
    model_clear;
    start = 1; tick; start = 0;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s run_entry in_ready/busy got %b%b exp 11", name, bus.in_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.a = 16'(ta[i]); bus.b = 16'(tb_[i]); bus.r = tr[i];
      model_add(ta[i], tb_[i], tr[i]);
      tick;
    end
    bus.in_valid = 0;
    n = 0;
    while (done !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (done !== 1'b1 || n != 2) begin errors++; $display("FAIL %s done_latency got done=%b after %0d cycles exp 1 after 2", name, done, n); end
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s busy/in_ready got %b%b exp 00", name, busy, bus.in_ready); end
    checks++; if (sample_cnt !== 32'(m_cnt)) begin errors++; $display("FAIL %s sample_cnt got %0d exp %0d", name, sample_cnt, m_cnt); end
    checks++; if (err_cnt !== 32'(m_err)) begin errors++; $display("FAIL %s err_cnt got %0d exp %0d", name, err_cnt, m_err); end
    checks++; if (ed_sum !== SW'(m_sum)) begin errors++; $display("FAIL %s ed_sum got %0d exp %0d", name, ed_sum, m_sum); end
    checks++; if (ed_max !== 32'(m_max)) begin errors++; $display("FAIL %s ed_max got %0d exp %0d", name, ed_max, m_max); end
    checks++; if (max_a !== 16'(m_a) || max_b !== 16'(m_b)) begin errors++; $display("FAIL %s max_ab got %0d,%0d exp %0d,%0d", name, max_a, max_b, m_a, m_b); end
`ifdef CDM_ERR_SQ_EN
    checks++; if (ed_sq_sum !== (2*SW)'(m_sq)) begin errors++; $display("FAIL %s ed_sq_sum got %0d exp %0d", name, ed_sq_sum, m_sq); end
`endif
  endtask
  task automatic test_exact;
    ta = '{3, 7, 0, 1}; tb_ = '{5, 9, 123, 1}; tr = '{15, 63, 0, 1};
    test_batch("exact");
  endtask
  task automatic test_max_err;
    ta = '{65535, 2, 0, 1}; tb_ = '{65535, 2, 0, 1}; tr = '{0, 10, 0, 1};
    test_batch("max_err");
    checks++; if (ed_max !== 32'd4294836225 || ed_sum !== 33'd4294836231) begin errors++; $display("FAIL max_err_const ed_max/ed_sum got %0d/%0d exp 4294836225/4294836231", ed_max, ed_sum); end
    checks++; if (max_a !== 16'd65535 || max_b !== 16'd65535 || err_cnt !== 32'd2) begin errors++; $display("FAIL max_err_const a/b/err got %0d/%0d/%0d exp 65535/65535/2", max_a, max_b, err_cnt); end
  endtask
  task automatic test_tie;
    ta = '{4, 3, 0, 0}; tb_ = '{4, 4, 0, 0}; tr = '{10, 6, 0, 0};
    test_batch("tie");
    checks++; if (max_a !== 16'd4 || max_b !== 16'd4 || ed_max !== 32'd6) begin errors++; $display("FAIL tie_const got %0d,%0d ed %0d exp 4,4 ed 6", max_a, max_b, ed_max); end
  endtask
  task automatic test_saturate;
    ta = '{65535, 65535, 65535, 65535}; tb_ = '{65535, 65535, 65535, 65535}; tr = '{0, 0, 0, 0};
    test_batch("saturate");
    checks++; if (ed_sum !== {SW{1'b1}}) begin errors++; $display("FAIL saturate_const ed_sum got %0d exp %0d", ed_sum, SAT); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        int unsigned p;
        ta[i] = $urandom_range(0, 65535);
        tb_[i] = $urandom_range(0, 65535);
        p = ta[i] * tb_[i];
        case ($urandom_range(0, 2))
          0: tr[i] = p;
          1: tr[i] = p + $urandom_range(0, 64) - 32;
          default: tr[i] = $urandom;
        endcase
      end
      test_batch($sformatf("random%0d", k));
    end
  endtask
  task automatic test_hold_valid;
    logic ir[12], dn[12];
    int acc, last;
    model_clear;
    acc = 0; last = -1;
    start = 1; tick; start = 0;
    bus.in_valid = 1;
    for (int c = 0; c < 12; c++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.r = $urandom;
      if (bus.in_ready === 1'b1) begin
        acc++; last = c;
        model_add(32'(bus.a), 32'(bus.b), bus.r);
      end
      tick;
      ir[c] = bus.in_ready; dn[c] = done;
    end
    bus.in_valid = 0;
    checks++; if (acc != N || last < 0 || last > 9) begin errors++; $display("FAIL hold_accepts got %0d exp %0d", acc, N); end
    else begin
      checks++; if (ir[last] !== 1'b0) begin errors++; $display("FAIL hold_ready_drop got %b exp 0", ir[last]); end
      checks++; if ({dn[last], dn[last+1], dn[last+2]} !== 3'b001) begin errors++; $display("FAIL hold_done_timing got %b exp 001", {dn[last], dn[last+1], dn[last+2]}); end
    end
    checks++; if (sample_cnt !== 32'(m_cnt) || ed_sum !== SW'(m_sum) || ed_max !== 32'(m_max)) begin errors++; $display("FAIL hold_stats got %0d/%0d/%0d exp %0d/%0d/%0d", sample_cnt, ed_sum, ed_max, m_cnt, m_sum, m_max); end
  endtask
  task automatic test_clr_start;
    start = 1; tick; start = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.a = 16'(i + 2); bus.b = 16'd3; bus.r = 32'((i + 2) * 3 + 1);
      tick;
    end
    bus.in_valid = 0;
    checks++; if (sample_cnt !== 32'd1 || ed_sum !== 33'd1) begin errors++; $display("FAIL clr_pre_latency got cnt %0d sum %0d exp 1/1", sample_cnt, ed_sum); end
    clr = 1; start = 1; tick; clr = 0; start = 0;
    checks++; if ({bus.in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL clr_flags got %b exp 000", {bus.in_ready, busy, done}); end
    checks++; if (sample_cnt !== 0 || err_cnt !== 0 || ed_sum !== 0 || ed_max !== 0 || max_a !== 0) begin errors++; $display("FAIL clr_stats got %0d %0d %0d %0d %0d exp 0", sample_cnt, err_cnt, ed_sum, ed_max, max_a); end
    tick; tick; tick;
    checks++; if (sample_cnt !== 0 || ed_sum !== 0 || busy !== 1'b0) begin errors++; $display("FAIL clr_flush got cnt %0d sum %0d busy %b exp 0 0 0", sample_cnt, ed_sum, busy); end
  endtask
  task automatic test_reset_mid;
    start = 1; tick; start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.a = 16'd5; bus.b = 16'd5; bus.r = 32'd20;
      tick;
    end
    bus.in_valid = 0;
    rst = 1; tick; rst = 0;
    checks++; if ({bus.in_ready, busy, done} !== 3'b000 || sample_cnt !== 0 || ed_sum !== 0 || ed_max !== 0) begin errors++; $display("FAIL rst_mid got flags %b cnt %0d sum %0d max %0d exp 0", {bus.in_ready, busy, done}, sample_cnt, ed_sum, ed_max); end
    tick; tick; tick;
    checks++; if (sample_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flush got cnt %0d err %0d busy %b exp 0 0 0", sample_cnt, err_cnt, busy); end
  endtask
`ifdef CDM_ERR_SQ_EN
  task automatic test_sq;
    ta = '{2, 0, 0, 0}; tb_ = '{2, 0, 0, 0}; tr = '{10, 0, 0, 0};
    test_batch("sq");
    checks++; if (ed_sq_sum !== 66'd36) begin errors++; $display("FAIL sq_const got %0d exp 36", ed_sq_sum); end
  endtask
`endif
  initial begin
    test_reset;
    test_exact;
    test_max_err;
    test_tie;
    test_saturate;
    test_random;
    test_hold_valid;
    test_clr_start;
    test_reset_mid;
`ifdef CDM_ERR_SQ_EN
    test_sq;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
